// File: rtl/res_packer.sv
// Packs result bytes into 255-bit words: 31 data bytes, 6-bit byte count, last flag.
// Define RES_PACKER_TIMEOUT_EN to flush idle partial words after TIMEOUT_CYCLES.
module res_packer #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             in_valid_i,
   input  logic [7:0]       in_data_i,
   input  logic             in_last_i,
   output logic             in_ready_o,
   output logic             out_valid_o,
   output logic [254:0]     out_data_o,
   input  logic             out_ready_i,
   output logic [CNT_W-1:0] word_cnt_o
);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t             state_q, state_d;
   logic [247:0]       buf_q;
   logic [4:0]         cnt_q;
   logic               last_q;
   logic [CNT_W-1:0]   word_cnt_q;
   logic               acc, out_hs, timeout_hit;

   // Readiness is masked by reset_i so no byte is taken while reset is held.
   assign acc    = in_valid_i && (state_q == ACCUM) && !reset_i;
   assign out_hs = (state_q == HOLD) && out_ready_i;

`ifdef RES_PACKER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_q;
   logic            idle;

   assign idle        = (state_q == ACCUM) && (cnt_q != 5'd0) && !acc;
   assign timeout_hit = idle && (to_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (reset_i || !idle || timeout_hit) to_q <= '0;
      else                                 to_q <= to_q + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      case (state_q)
         ACCUM: begin
            in_ready_o = !reset_i;
            if (acc && (cnt_q == 5'd30 || in_last_i)) state_d = HOLD;
            else if (timeout_hit)                     state_d = HOLD;
         end
         HOLD: begin
            out_valid_o = 1'b1;
            if (out_ready_i) state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ACCUM;
         buf_q      <= '0;
         cnt_q      <= '0;
         last_q     <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (acc) begin
            buf_q[{cnt_q, 3'b000} +: 8] <= in_data_i;
            cnt_q                       <= cnt_q + 5'd1;
            // Only the closing byte can carry last, so earlier writes of 0 are harmless.
            last_q                      <= in_last_i;
         end
         if (out_hs) begin
            buf_q      <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            word_cnt_q <= word_cnt_q + 1'b1;
         end
      end
   end

   assign out_data_o = {last_q, 1'b0, cnt_q, buf_q};
   assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_res_packer.sv
// Randomized scoreboard bench for res_packer: stimulus pushes expected words, a monitor pops them.
module tb_res_packer;
   localparam int CNT_W = 4;
   localparam int TO    = 64;

   logic             clk_i = 1'b0;
   logic             reset_i = 1'b1;
   logic             in_valid_i = 1'b0;
   logic [7:0]       in_data_i = '0;
   logic             in_last_i = 1'b0;
   logic             in_ready_o;
   logic             out_valid_o;
   logic [254:0]     out_data_o;
   logic             out_ready_i;
   logic [CNT_W-1:0] word_cnt_o;

   always #5 clk_i = ~clk_i;

   res_packer #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
      .in_last_i(in_last_i), .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
      .out_data_o(out_data_o), .out_ready_i(out_ready_i), .word_cnt_o(word_cnt_o)
   );

   int               n_chk = 0, n_pass = 0;
   int               mode = 0;          // 0: sink ready, 1: random, 2: stalled
   int               cyc = 0, acc_cyc = 0;
   logic [254:0]     exp_q[$];
   logic [7:0]       pb[$];
   logic [CNT_W-1:0] exp_wc = '0;
   bit               wc_pend = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic void check(string nm, logic [254:0] got, logic [254:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endfunction

   // Reference: a word is the list of accepted bytes, their count and the closing flag.
   function automatic logic [254:0] build(input logic l);
      logic [254:0] w = '0;
      for (int k = 0; k < pb.size(); k++) w[8*k +: 8] = pb[k];
      w[253:248] = 6'(pb.size());
      w[254]     = l;
      return w;
   endfunction

   function automatic void model_push(input logic [7:0] d, input logic l);
      pb.push_back(d);
      if (pb.size() == 31 || l) begin
         exp_q.push_back(build(l));
         pb.delete();
      end
   endfunction

   always @(negedge clk_i) begin
      if (wc_pend) begin
         check("word_cnt", 255'(word_cnt_o), 255'(exp_wc));
         wc_pend = 0;
      end
      case (mode)
         0:       out_ready_i = 1'b1;
         1:       out_ready_i = 1'($urandom_range(0, 1));
         default: out_ready_i = 1'b0;
      endcase
      if (out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_word: got %h expected none", out_data_o);
         end else check("word", out_data_o, exp_q.pop_front());
         exp_wc  = exp_wc + 1'b1;
         wc_pend = 1;
      end
   end

   task automatic send(input logic [7:0] d, input logic l);
      int w = 0;
      @(negedge clk_i);
      in_valid_i = 1'b1; in_data_i = d; in_last_i = l;
      while (!in_ready_o && w < 200) begin @(negedge clk_i); w++; end
      if (!in_ready_o) begin
         n_chk++;
         $display("FAIL accept_timeout: got ready=0 expected ready=1");
      end else begin
         @(posedge clk_i);
         acc_cyc = cyc;
         model_push(d, l);
      end
   endtask

   task automatic idle();
      @(negedge clk_i);
      in_valid_i = 1'b0; in_last_i = 1'b0;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk_i);
      reset_i = 1'b1;
      repeat (n) @(negedge clk_i);
      check("rst_in_ready", 255'(in_ready_o), 255'(0));
      check("rst_out_valid", 255'(out_valid_o), 255'(0));
      check("rst_out_data", out_data_o, 255'(0));
      check("rst_word_cnt", 255'(word_cnt_o), 255'(0));
      reset_i = 1'b0;
      pb.delete();
      exp_wc = '0;
      @(negedge clk_i);
      check("post_rst_in_ready", 255'(in_ready_o), 255'(1));
   endtask

   task automatic wait_drain();
      int w = 0;
      while ((exp_q.size() != 0 || out_valid_o) && w < 2000) begin @(negedge clk_i); w++; end
      if (exp_q.size() != 0 || out_valid_o) begin
         n_chk++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(negedge clk_i);
   endtask

   initial begin
      int c0;
      do_reset(3);

      // Full word of 0x01..0x1F, sink always ready.
      for (int i = 1; i <= 31; i++) send(8'(i), 1'b0);
      idle();
      wait_drain();

      // Short word closed by last; valid must follow the accept by one cycle.
      send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b1);
      @(negedge clk_i);
      check("last_valid_next", 255'(out_valid_o), 255'(1));
      check("last_ready_low", 255'(in_ready_o), 255'(0));
      in_valid_i = 1'b0; in_last_i = 1'b0;
      wait_drain();

      // Throughput: 62 bytes back-to-back with a ready sink.
      send(8'h10, 1'b0);
      c0 = acc_cyc;
      for (int i = 1; i < 62; i++) send(8'(i + 8'h10), 1'b0);
      check("throughput", 255'((acc_cyc - c0) <= 63), 255'(1));
      idle();
      wait_drain();

      // Stalled sink: held word stable, input blocked, next byte goes to slot 0.
      mode = 2;
      for (int i = 0; i < 31; i++) send(8'(i + 8'h40), 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         in_valid_i = 1'b1; in_data_i = 8'h55; in_last_i = 1'b0;
         check("stall_in_ready", 255'(in_ready_o), 255'(0));
         check("stall_data", out_data_o, exp_q[0]);
      end
      @(posedge clk_i);
      mode = 0;
      send(8'h55, 1'b0); send(8'h66, 1'b1);
      idle();
      wait_drain();

      // Partial word left idle: flushed only when the timeout feature is built in.
      for (int i = 0; i < 5; i++) send(8'(i + 8'h90), 1'b0);
      idle();
`ifdef RES_PACKER_TIMEOUT_EN
      exp_q.push_back(build(1'b0));
      pb.delete();
`endif
      repeat (1000) @(negedge clk_i);
      check("idle_no_word", 255'(out_valid_o), 255'(0));
      send(8'h77, 1'b1);
      idle();
      wait_drain();

      // Reset mid-word discards the partial bytes.
      for (int i = 0; i < 10; i++) send(8'(i + 8'hE0), 1'b0);
      idle();
      do_reset(1);
      for (int i = 0; i < 31; i++) send(8'(i + 8'h20), 1'b0);
      idle();
      wait_drain();

      // Randomized traffic with random sink backpressure; enough words to wrap word_cnt_o.
      mode = 1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) idle();
         send(8'($urandom), 1'($urandom_range(0, 7) == 0));
      end
      send(8'h5A, 1'b1);
      idle();
      @(posedge clk_i);
      mode = 0;
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
